module_debouncer_nch: RTL and testbench

Parametrised multi-channel successor to the single-button debouncer. Each of N_CH raw push-button inputs is synchronised, then declared stable only after it holds a new level for STABLE_CYCLES sample ticks. Each channel produces a clean level plus one-cycle rise/fall pulses for downstream FSMs. Sits between board pins and control logic; all channels share one clock and one optional sample-enable tick.

---
 rtl/module_debouncer_nch_if.sv | 31 +++
 rtl/module_debouncer_nch.sv | 82 ++++++++
 tb/tb_module_debouncer_nch.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/module_debouncer_nch_if.sv
`default_nettype none
// ============================================================================
// module_debouncer_nch_if : button inputs, sample tick and debounced outputs
// Rev 1.0
// ============================================================================
interface module_debouncer_nch_if #(
  parameter int N_CH = 4
) ();
  logic            tick_en;
  logic [N_CH-1:0] pb_in;
  logic [N_CH-1:0] pb_out;
  logic [N_CH-1:0] pb_rise;
  logic [N_CH-1:0] pb_fall;

  modport master (
    output tick_en,
    output pb_in,
    input  pb_out,
    input  pb_rise,
    input  pb_fall
  );

  modport slave (
    input  tick_en,
    input  pb_in,
    output pb_out,
    output pb_rise,
    output pb_fall
  );
endinterface
`default_nettype wire

// File: rtl/module_debouncer_nch.sv
`default_nettype none
// ============================================================================
// module_debouncer_nch : N-channel push-button debouncer with rise/fall pulses
// Rev 1.0
// ============================================================================
module module_debouncer_nch #(
  parameter int N_CH          = 4,
  parameter int STABLE_CYCLES = 10,
  parameter int SYNC_STAGES   = 2,
  parameter int ACTIVE_LOW    = 0
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  module_debouncer_nch_if.slave bus
);
  localparam int               CNT_W    = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic             POL      = (ACTIVE_LOW != 0);

  logic [N_CH-1:0] out_vec;
  logic [N_CH-1:0] rise_vec;
  logic [N_CH-1:0] fall_vec;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       cnt_d;
    logic                   out_q, out_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   s;

    // Polarity is normalised before the synchroniser so everything downstream is 1 = pressed.
    assign sync_d = {sync_q[SYNC_STAGES-2:0], bus.pb_in[i] ^ POL};
    assign s      = sync_q[SYNC_STAGES-1];

    always_comb begin
      cnt_d  = cnt_q;
      out_d  = out_q;
      rise_d = 1'b0;
      fall_d = 1'b0;
      if (s == out_q) begin
        cnt_d = '0;
      end else if (bus.tick_en) begin
        if (cnt_q == CNT_LAST) begin
          out_d  = s;
          cnt_d  = '0;
          rise_d = s;
          fall_d = ~s;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        sync_q <= '0;
        cnt_q  <= '0;
        out_q  <= 1'b0;
        rise_q <= 1'b0;
        fall_q <= 1'b0;
      end else begin
        sync_q <= sync_d;
        cnt_q  <= cnt_d;
        out_q  <= out_d;
        rise_q <= rise_d;
        fall_q <= fall_d;
      end
    end

    assign out_vec[i]  = out_q;
    assign rise_vec[i] = rise_q;
    assign fall_vec[i] = fall_q;
  end

  assign bus.pb_out  = out_vec;
  assign bus.pb_rise = rise_vec;
  assign bus.pb_fall = fall_vec;
endmodule
`default_nettype wire

// File: tb/tb_module_debouncer_nch.sv
`default_nettype none
// ============================================================================
// tb_module_debouncer_nch : three debouncer variants against a history-based model
// Rev 1.0
// ============================================================================
module tb_module_debouncer_nch;
  localparam int NC   = 2;
  localparam int SY   = 2;
  localparam int ND   = 3;
  localparam int HMAX = 32768;
  localparam int SC_TAB [ND] = '{10, 3, 1};
  localparam int AL_TAB [ND] = '{0, 1, 0};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic [NC-1:0] raw;
  logic          tick;

  module_debouncer_nch_if #(.N_CH(NC)) if_a ();
  module_debouncer_nch_if #(.N_CH(NC)) if_b ();
  module_debouncer_nch_if #(.N_CH(NC)) if_c ();

  module_debouncer_nch #(.N_CH(NC), .STABLE_CYCLES(10), .SYNC_STAGES(SY), .ACTIVE_LOW(0))
    dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a));
  module_debouncer_nch #(.N_CH(NC), .STABLE_CYCLES(3), .SYNC_STAGES(SY), .ACTIVE_LOW(1))
    dut_b (.clk(clk), .rst_n(rst_n), .bus(if_b));
  module_debouncer_nch #(.N_CH(NC), .STABLE_CYCLES(1), .SYNC_STAGES(SY), .ACTIVE_LOW(0))
    dut_c (.clk(clk), .rst_n(rst_n), .bus(if_c));

  int n_vec = 0;
  int n_err = 0;

  // Model: the synchronised level at edge e is the pin level sampled SY edges earlier,
  // provided no reset edge came in between; acceptance needs SC ticked mismatch cycles in a row.
  int edge_n   = 0;
  int last_rst = 0;
  bit hist   [ND][NC][HMAX];
  bit m_out  [ND][NC];
  bit m_rise [ND][NC];
  bit m_fall [ND][NC];
  int m_run  [ND][NC];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h exp=%0h (edge %0d)", tag, got, exp, edge_n);
    end
  endtask

  task automatic drive(input logic [NC-1:0] r, input logic t, input logic rn);
    raw          = r;
    tick         = t;
    rst_n        = rn;
    if_a.pb_in   = r;
    if_b.pb_in   = ~r;
    if_c.pb_in   = r;
    if_a.tick_en = t;
    if_b.tick_en = t;
    if_c.tick_en = t;
  endtask

  task automatic model_step();
    bit pin, lvl, s;
    edge_n++;
    if (!rst_n) last_rst = edge_n;
    for (int d = 0; d < ND; d++) begin
      for (int c = 0; c < NC; c++) begin
        pin = (d == 1) ? !raw[c] : raw[c];
        lvl = pin ^ (AL_TAB[d] != 0);
        if (!rst_n) begin
          m_out[d][c]  = 1'b0;
          m_rise[d][c] = 1'b0;
          m_fall[d][c] = 1'b0;
          m_run[d][c]  = 0;
        end else begin
          s = (edge_n - SY > last_rst) ? hist[d][c][edge_n - SY] : 1'b0;
          m_rise[d][c] = 1'b0;
          m_fall[d][c] = 1'b0;
          if (s == m_out[d][c]) begin
            m_run[d][c] = 0;
          end else if (tick) begin
            m_run[d][c] = m_run[d][c] + 1;
            if (m_run[d][c] == SC_TAB[d]) begin
              m_out[d][c]  = s;
              m_run[d][c]  = 0;
              m_rise[d][c] = s;
              m_fall[d][c] = !s;
            end
          end
        end
        if (edge_n < HMAX) hist[d][c][edge_n] = lvl;
      end
    end
  endtask

  task automatic cmp_dut(input int d, input logic [NC-1:0] o, input logic [NC-1:0] r,
                         input logic [NC-1:0] f);
    logic [NC-1:0] eo, er, ef;
    for (int c = 0; c < NC; c++) begin
      eo[c] = m_out[d][c];
      er[c] = m_rise[d][c];
      ef[c] = m_fall[d][c];
    end
    chk($sformatf("dut%0d.pb_out", d),  32'(o), 32'(eo));
    chk($sformatf("dut%0d.pb_rise", d), 32'(r), 32'(er));
    chk($sformatf("dut%0d.pb_fall", d), 32'(f), 32'(ef));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    cmp_dut(0, if_a.pb_out, if_a.pb_rise, if_a.pb_fall);
    cmp_dut(1, if_b.pb_out, if_b.pb_rise, if_b.pb_fall);
    cmp_dut(2, if_c.pb_out, if_c.pb_rise, if_c.pb_fall);
  endtask

  task automatic hold(input logic [NC-1:0] r, input int len);
    drive(r, 1'b1, 1'b1);
    repeat (len) cycle();
  endtask

  // Edge count from the new level to the first pulse, checked directly against SY+SC.
  task automatic lat_test(input logic [NC-1:0] r);
    int first [ND];
    for (int d = 0; d < ND; d++) first[d] = 0;
    drive(r, 1'b1, 1'b1);
    for (int n = 1; n <= 30; n++) begin
      cycle();
      if (first[0] == 0 && (if_a.pb_rise | if_a.pb_fall) != '0) first[0] = n;
      if (first[1] == 0 && (if_b.pb_rise | if_b.pb_fall) != '0) first[1] = n;
      if (first[2] == 0 && (if_c.pb_rise | if_c.pb_fall) != '0) first[2] = n;
    end
    for (int d = 0; d < ND; d++)
      chk($sformatf("dut%0d.latency", d), 32'(first[d]), 32'(SY + SC_TAB[d]));
  endtask

  initial begin
    logic [NC-1:0] r;
    int rate;
    bit tick_rnd;

    drive('0, 1'b1, 1'b0);
    repeat (3) cycle();
    hold('0, 5);

    lat_test(2'b01);
    lat_test(2'b00);
    lat_test(2'b11);
    lat_test(2'b00);

    hold(2'b01, 6); hold(2'b00, 3); hold(2'b01, 6); hold(2'b00, 20);
    lat_test(2'b01);
    lat_test(2'b00);

    hold(2'b01, 9);  hold(2'b00, 20);
    hold(2'b01, 10); hold(2'b00, 30);

    for (int k = 0; k < 200; k++) begin
      drive(2'b01, (k % 4) == 0, 1'b1);
      cycle();
    end
    for (int k = 0; k < 200; k++) begin
      drive(2'b00, (k % 4) == 1, 1'b1);
      cycle();
    end

    hold(2'b01, 9);
    drive(2'b01, 1'b1, 1'b0);
    repeat (3) cycle();
    lat_test(2'b01);
    hold(2'b00, 30);

    r = '0;
    for (int seg = 0; seg < 40; seg++) begin
      rate     = $urandom_range(2, 40);
      tick_rnd = ($urandom_range(0, 1) == 1);
      for (int k = 0; k < 100; k++) begin
        for (int c = 0; c < NC; c++)
          if ($urandom_range(0, rate - 1) == 0) r[c] = ~r[c];
        drive(r, tick_rnd ? ($urandom_range(0, 3) != 0) : 1'b1, $urandom_range(0, 299) != 0);
        cycle();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
`default_nettype wire
